lmc_prog_ram: RTL
=================

LMC_PROG_RAM -- requirements
Module: lmc_prog_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address bits; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per word.
REQ-003 SHALL have parameter AUTO_INC, default 1, 1 = counter advances after each LOAD write.
REQ-004 SHALL have parameter STOP_AT_END, default 0, 1 = RUN halts at last address instead of wrapping.
REQ-005 SHALL have port timer555  input  1  sole clock, rising edge active.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port mode  input  1  0 = LOAD, 1 = RUN request.
REQ-008 SHALL have port step_en  input  1  RUN-mode counter advance enable.
REQ-009 SHALL have port ram_button  input  1  write request, level, asynchronous to timer555.
REQ-010 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-011 SHALL have port jump  input  1  load counter from jump_addr.
REQ-012 SHALL have port jump_addr  input  ADDR_WIDTH  jump target.
REQ-013 SHALL have port ram_out  output  DATA_WIDTH  mem[counter], combinational read.
REQ-014 SHALL have port counter  output  ADDR_WIDTH  current address.
REQ-015 SHALL have port state  output  2  LOAD=0, RUN=1, HALT=2.
REQ-016 SHALL have port wr_ack  output  1  one-cycle pulse per completed write.
REQ-017 SHALL have port wrap  output  1  one-cycle pulse when counter goes max->0 or reaches HALT.

Function
REQ-018 SHALL detect ram_button rising edge on timer555; one press = exactly one write regardless of hold length.
REQ-019 SHALL, in LOAD on a detected edge, write data_in to mem[counter] at that clock and assert wr_ack the next cycle.
REQ-020 SHALL, when AUTO_INC=1, increment counter on the same clock as the write; AUTO_INC=0 leaves counter unchanged.
REQ-021 SHALL ignore button edges in RUN and HALT (no write, no wr_ack).
REQ-022 SHALL, in RUN with step_en=1, increment counter each clock; step_en=0 holds counter.
REQ-023 SHALL wrap counter from 2**ADDR_WIDTH-1 to 0 and pulse wrap (LOAD auto-increment and RUN with STOP_AT_END=0).
REQ-024 SHALL, with STOP_AT_END=1, on RUN step at max address hold counter at max, enter HALT, pulse wrap.
REQ-025 SHALL FSM: LOAD->RUN when mode=1; RUN->LOAD when mode=0; HALT->LOAD when mode=0; HALT ignores step_en.
REQ-026 SHALL give jump priority over increment in every state; write plus jump same clock: write uses old counter, counter becomes jump_addr; jump in HALT stays HALT.
REQ-027 SHALL present ram_out = mem[counter] with zero-cycle latency, reflecting a write to the current address the cycle after it.

Reset
REQ-028 SHALL, on reset_n low, immediately force counter=0, state=LOAD, wr_ack=0, wrap=0, edge detector cleared (button held through reset produces no write).
REQ-029 SHALL NOT reset memory contents; reset mid-RUN loses no stored word.

Configuration
REQ-030 SHALL honour macro LMC_PROG_RAM_BTN_SYNC_EN: defined -> ram_button passes a two-flop synchroniser before edge detect (write 3 clocks after press); undefined -> edge detect on raw input (write 1 clock after press).

Structure
REQ-031 SHALL place state encoding (LOAD/RUN/HALT) and the 2-bit state typedef in shared package lmc_pkg.
REQ-032 SHALL isolate synchroniser plus rising-edge detector in sub-module lmc_btn_edge.

Verification
REQ-033 SHALL test: reset, LOAD, press with data_in 0x11,0x22,0x33 -> mem[0..2]=0x11,0x22,0x33, counter=3, three wr_ack pulses.
REQ-034 SHALL test: button held 10 clocks in LOAD -> exactly one write, one wr_ack.
REQ-035 SHALL test: RUN, step_en=1, counter 14, ADDR_WIDTH=4 -> 15 then 0, wrap pulses once; STOP_AT_END=1 -> counter stays 15, state=HALT.
REQ-036 SHALL test: LOAD, counter=5, press and jump to 9 same clock -> mem[5]=data_in, counter=9.
REQ-037 SHALL test: RUN at counter 7, reset_n pulsed low -> counter=0, state=LOAD, mem[7] unchanged.
REQ-038 SHALL test: with and without LMC_PROG_RAM_BTN_SYNC_EN -> press-to-write latency 3 and 1 clocks respectively.

Source files
------------

// File: rtl/lmc_prog_ram_pkg.sv
// Shared definitions for the LMC program RAM: 2-bit state type and its encodings.
package lmc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

endpackage

// File: rtl/lmc_prog_ram_if.sv
// Bus between a program-RAM controller (master) and lmc_prog_ram (slave).
interface lmc_prog_ram_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    import lmc_pkg::*;

    logic                  mode;
    logic                  step_en;
    logic                  ram_button;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic [DATA_WIDTH-1:0] ram_out;
    logic [ADDR_WIDTH-1:0] counter;
    state_t                state;
    logic                  wr_ack;
    logic                  wrap;

    modport master (
        output mode, step_en, ram_button, data_in, jump, jump_addr,
        input  ram_out, counter, state, wr_ack, wrap
    );

    modport slave (
        input  mode, step_en, ram_button, data_in, jump, jump_addr,
        output ram_out, counter, state, wr_ack, wrap
    );

endinterface

// File: rtl/lmc_prog_ram_btn_edge.sv
// Rising-edge detector for the write button. Define LMC_PROG_RAM_BTN_SYNC_EN
// to insert a two-flop synchroniser ahead of the detector.
module lmc_btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic btn_s;
    logic btn_prev;

`ifdef LMC_PROG_RAM_BTN_SYNC_EN
    logic sync1;
    logic sync2;

    // Reset to 1 so a button already held across reset never looks like a new press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2;
`else
    assign btn_s = btn;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_s;
        end
    end

    assign rise = btn_s & ~btn_prev;

endmodule

// File: rtl/lmc_prog_ram.sv
// LMC program RAM: button-driven LOAD writes, stepped RUN readout, optional halt at end.
// Button synchroniser enabled by LMC_PROG_RAM_BTN_SYNC_EN (see lmc_btn_edge).
module lmc_prog_ram #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int AUTO_INC    = 1,
    parameter int STOP_AT_END = 0
) (
    input  logic            timer555,
    input  logic            reset_n,
    lmc_prog_ram_if.slave   bus
);
    import lmc_pkg::*;

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    state_t                st_q;
    state_t                st_nxt;
    logic                  btn_rise;
    logic                  wr_en;
    logic                  wrap_nxt;
    logic                  wr_ack_q;
    logic                  wrap_q;

    lmc_btn_edge u_btn_edge (
        .clk     (timer555),
        .reset_n (reset_n),
        .btn     (bus.ram_button),
        .rise    (btn_rise)
    );

    assign wr_en = btn_rise && (st_q == ST_LOAD);

    always_comb begin
        cnt_nxt  = cnt_q;
        st_nxt   = st_q;
        wrap_nxt = 1'b0;
        case (st_q)
            ST_LOAD: begin
                if (wr_en && (AUTO_INC != 0)) begin
                    cnt_nxt  = cnt_q + ADDR_WIDTH'(1);
                    wrap_nxt = (cnt_q == CNT_MAX);
                end
                if (bus.mode) st_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.mode) begin
                    st_nxt = ST_LOAD;
                end else if (bus.step_en) begin
                    wrap_nxt = (cnt_q == CNT_MAX);
                    if ((cnt_q == CNT_MAX) && (STOP_AT_END != 0)) begin
                        st_nxt = ST_HALT;
                    end else begin
                        cnt_nxt = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_HALT: begin
                if (!bus.mode) st_nxt = ST_LOAD;
            end
            default: st_nxt = ST_LOAD;
        endcase
        // A jump overrides any step, including the wrap pulse and the move into HALT.
        if (bus.jump) begin
            cnt_nxt  = bus.jump_addr;
            wrap_nxt = 1'b0;
            if (st_q == ST_RUN && st_nxt == ST_HALT) st_nxt = ST_RUN;
        end
    end

    always_ff @(posedge timer555 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            st_q     <= ST_LOAD;
            wr_ack_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            st_q     <= st_nxt;
            wr_ack_q <= wr_en;
            wrap_q   <= wrap_nxt;
        end
    end

    // Program storage survives reset; the write uses the pre-jump/pre-increment address.
    always_ff @(posedge timer555) begin
        if (wr_en) mem[cnt_q] <= bus.data_in;
    end

    assign bus.ram_out = mem[cnt_q];
    assign bus.counter = cnt_q;
    assign bus.state   = st_q;
    assign bus.wr_ack  = wr_ack_q;
    assign bus.wrap    = wrap_q;

endmodule
